// File: rtl/mmu_sram_resp_pkg.sv
// Shared operation encodings and state type for the MMU-side SRAM responder.
package mmu_sram_resp_pkg;

  localparam int MEM_OPT_WIDTH = 3;

  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 3'd0;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 3'd1;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 3'd2;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LB   = 3'd3;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 3'd4;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Codes 6 and 7 are reserved and behave exactly like NONE.
  function automatic logic opt_is_load(input logic [MEM_OPT_WIDTH-1:0] opt);
    return (opt == MEM_OPT_LW) || (opt == MEM_OPT_LB) || (opt == MEM_OPT_LBU);
  endfunction

  function automatic logic opt_is_store(input logic [MEM_OPT_WIDTH-1:0] opt);
    return (opt == MEM_OPT_SW) || (opt == MEM_OPT_SB);
  endfunction

  function automatic logic opt_valid(input logic [MEM_OPT_WIDTH-1:0] opt);
    return opt_is_load(opt) || opt_is_store(opt);
  endfunction

endpackage

// File: rtl/mmu_load_fmt.sv
// Combinational load formatter: picks the addressed byte lane and extends it,
// or passes the whole word through for LW.
module mmu_load_fmt
  import mmu_sram_resp_pkg::*;
(
  input  logic [MEM_OPT_WIDTH-1:0] opt,
  input  logic [1:0]               off,
  input  logic [31:0]              word,
  output logic [31:0]              result
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    case (opt)
      MEM_OPT_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OPT_LBU: result = {24'h000000, byte_sel};
      default:     result = word;
    endcase
  end

endmodule

// File: rtl/mmu_sram_resp.sv
// MMU-side responder driving a timed access on an asynchronous 32-bit SRAM.
// Optional word-alignment check enabled with `define MMU_ALIGN_CHECK_EN.
module mmu_sram_resp
  import mmu_sram_resp_pkg::*;
#(
  parameter int ADDR_BITS   = 20,
  parameter int WAIT_CYCLES = 2
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MEM_OPT_WIDTH-1:0] req_opt,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic [31:0]              rsp_rdata,
  output logic                     busy,
  output logic                     addr_err,
  output logic [ADDR_BITS-1:0]     sram_addr,
  output logic [31:0]              sram_dout,
  input  logic [31:0]              sram_din,
  output logic                     sram_doe,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic [3:0]               sram_be_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [MEM_OPT_WIDTH-1:0] opt_q;
  logic [1:0]               off_q;
  logic                     req_valid;
  logic                     accept;
  logic                     misaligned;
  logic [31:0]              load_result;
  logic                     unused_addr_bits;

  assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_BITS+2]};
  assign req_valid        = opt_valid(req_opt);

`ifdef MMU_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((req_opt == MEM_OPT_LW) || (req_opt == MEM_OPT_SW)) &&
                      (req_addr[1:0] != 2'b00);
  assign addr_err   = err_q;

  // Rejected word access: the pulse lands in the DONE cycle it shares with busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign addr_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // busy must rise in the request cycle itself, hence the combinational IDLE term.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = req_valid;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = misaligned ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  mmu_load_fmt u_load_fmt (
    .opt    (opt_q),
    .off    (off_q),
    .word   (sram_din),
    .result (load_result)
  );

  // SRAM strobes are registered so the pads see clean levels from the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      opt_q     <= MEM_OPT_NONE;
      off_q     <= 2'b00;
      rsp_rdata <= 32'h0;
      sram_addr <= '0;
      sram_dout <= 32'h0;
      sram_doe  <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 4'hF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opt_q <= req_opt;
            off_q <= req_addr[1:0];
            cnt   <= CNT_FIRST;
            if (!misaligned) begin
              sram_ce_n <= 1'b0;
              sram_addr <= req_addr[ADDR_BITS+1:2];
              if (opt_is_load(req_opt)) begin
                sram_oe_n <= 1'b0;
                sram_be_n <= 4'h0;
              end else if (req_opt == MEM_OPT_SW) begin
                sram_we_n <= 1'b0;
                sram_doe  <= 1'b1;
                sram_be_n <= 4'h0;
                sram_dout <= req_wdata;
              end else begin
                sram_we_n <= 1'b0;
                sram_doe  <= 1'b1;
                sram_be_n <= ~(4'b0001 << req_addr[1:0]);
                sram_dout <= {4{req_wdata[7:0]}};
              end
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == CNT_LAST) begin
            if (opt_is_load(opt_q)) begin
              rsp_rdata <= load_result;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_doe  <= 1'b0;
            sram_be_n <= 4'hF;
          end else begin
            cnt <= cnt + CNT_FIRST;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_sram_resp.sv
// Self-checking bench for mmu_sram_resp: SRAM pad model, transaction-level
// reference model with a per-cycle compare, and directed literal checks.
`timescale 1ns/1ps
module tb_mmu_sram_resp;
  import mmu_sram_resp_pkg::*;

  localparam int ADDR_BITS = 20;
  localparam int W         = 2;
`ifdef MMU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [MEM_OPT_WIDTH-1:0] req_opt;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic [31:0]              rsp_rdata;
  logic                     busy;
  logic                     addr_err;
  logic [ADDR_BITS-1:0]     sram_addr;
  logic [31:0]              sram_dout;
  logic [31:0]              sram_din;
  logic                     sram_doe;
  logic                     sram_ce_n;
  logic                     sram_oe_n;
  logic                     sram_we_n;
  logic [3:0]               sram_be_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mmu_sram_resp #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_opt   (req_opt),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .addr_err  (addr_err),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_doe  (sram_doe),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_be_n (sram_be_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM pads: a write is only committed after a we_n pulse of full width.
  logic [31:0] sram_mem [0:63];
  int          we_low = 0;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [5:0]  wr_idx;

  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      we_low++;
      wr_data = sram_dout;
      wr_be   = sram_be_n;
      wr_idx  = sram_addr[5:0];
    end else begin
      if (we_low >= W) begin
        for (int i = 0; i < 4; i++) begin
          if (!wr_be[i]) sram_mem[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
        end
      end
      we_low = 0;
    end
  end

  // Reference model: a transaction occupies W+2 busy cycles, results land W edges after accept.
  logic [31:0]              ref_mem [0:63];
  int                       m_left  = 0;
  logic [MEM_OPT_WIDTH-1:0] m_op    = MEM_OPT_NONE;
  logic [5:0]               m_idx   = 6'd0;
  logic [1:0]               m_off   = 2'd0;
  logic [31:0]              m_wdata = 32'h0;
  logic [31:0]              m_rdata = 32'h0;
  logic                     m_err   = 1'b0;
  logic                     m_mis   = 1'b0;

  function automatic logic [31:0] expect_load(input logic [2:0] op, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] b;
    b = (word >> (8 * off)) & 32'hFF;
    if (op == MEM_OPT_LW) return word;
    if (op == MEM_OPT_LB && b >= 32'd128) return b + 32'hFFFFFF00;
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_rdata = 32'h0;
      m_err   = 1'b0;
      m_mis   = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_left == 0) begin
        if (req_opt >= 3'd1 && req_opt <= 3'd5) begin
          m_op    = req_opt;
          m_idx   = req_addr[7:2];
          m_off   = req_addr[1:0];
          m_wdata = req_wdata;
          m_mis   = ALIGN_EN && (req_opt == MEM_OPT_LW || req_opt == MEM_OPT_SW) &&
                    (req_addr[1:0] != 2'd0);
          if (m_mis) begin
            m_left = 1;
            m_err  = 1'b1;
          end else begin
            m_left = W + 1;
          end
        end
      end else begin
        if (m_left == 2 && !m_mis) begin
          if (m_op == MEM_OPT_SW) ref_mem[m_idx] = m_wdata;
          else if (m_op == MEM_OPT_SB) ref_mem[m_idx][8*m_off +: 8] = m_wdata[7:0];
          else m_rdata = expect_load(m_op, ref_mem[m_idx], m_off);
        end
        m_left--;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic       win;
    logic       st;
    logic [3:0] exp_be;
    if (checking) begin
      win = (m_left >= 2) && !m_mis;
      st  = (m_op == MEM_OPT_SW) || (m_op == MEM_OPT_SB);
      exp_be = 4'hF;
      if (win) begin
        for (int i = 0; i < 4; i++) begin
          if (m_op != MEM_OPT_SB || i == int'(m_off)) exp_be[i] = 1'b0;
        end
      end
      check("busy", busy, ((m_left > 0) || (req_opt >= 3'd1 && req_opt <= 3'd5)) ? 1 : 0);
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("addr_err", addr_err, m_err);
      check("ce_n", sram_ce_n, !win);
      check("we_n", sram_we_n, !(win && st));
      check("oe_n", sram_oe_n, !(win && !st));
      check("doe", sram_doe, win && st);
      check("be_n", sram_be_n, exp_be);
      if (win) check("sram_addr", 32'(sram_addr), 32'(m_idx));
      if (win && m_op == MEM_OPT_SW) check("dout_sw", sram_dout, m_wdata);
      if (win && m_op == MEM_OPT_SB) check("dout_sb", sram_dout, {4{m_wdata[7:0]}});
    end
  end

  int         r_busy, r_we, r_ce, r_err;
  logic [3:0] r_be;
  logic [31:0] r_addr;

  // One request; gathers what the pads did until busy falls.
  task automatic run_req(input logic [2:0] opt, input logic [31:0] addr, input logic [31:0] wdata);
    int   guard;
    logic b;
    guard = 0;
    r_busy = 0; r_we = 0; r_ce = 0; r_err = 0; r_be = 4'hF; r_addr = 32'h0;
    @(posedge clk); #1;
    req_opt = opt; req_addr = addr; req_wdata = wdata;
    do begin
      @(negedge clk);
      b = busy;
      if (busy) r_busy++;
      if (!sram_we_n) r_we++;
      if (addr_err) r_err++;
      if (!sram_ce_n) begin
        r_ce++;
        r_be   = sram_be_n;
        r_addr = 32'(sram_addr);
      end
      @(posedge clk); #1;
      req_opt = MEM_OPT_NONE;
      guard++;
    end while (b && guard < 40);
    if (guard >= 40) check("busy_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    int b2b_busy;
    int gap;
    int idle_hits;
    logic [31:0] mis_expect;
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    rst = 1'b1; req_opt = MEM_OPT_NONE; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_be_n", sram_be_n, 4'hF);
    check("rst_doe", sram_doe, 0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dout", sram_dout, 32'h0);
    check("rst_addr_err", addr_err, 0);

    $display("[TB] word store and load");
    run_req(MEM_OPT_SW, 32'h0000_0010, 32'hDEADBEEF);
    check("sw_busy_cycles", r_busy, 4);
    check("sw_we_cycles", r_we, 2);
    check("sw_be", r_be, 4'h0);
    check("sw_addr", r_addr, 32'h4);
    run_req(MEM_OPT_LW, 32'h0000_0010, 32'h0);
    check("lw_result", rsp_rdata, 32'hDEADBEEF);
    check("lw_busy_cycles", r_busy, 4);

    $display("[TB] byte store and byte loads");
    run_req(MEM_OPT_SB, 32'h13, 32'h0000_0080);
    check("sb_be", r_be, 4'h7);
    check("sb_we_cycles", r_we, 2);
    run_req(MEM_OPT_LB, 32'h13, 32'h0);
    check("lb_13", rsp_rdata, 32'hFFFFFF80);
    run_req(MEM_OPT_LBU, 32'h13, 32'h0);
    check("lbu_13", rsp_rdata, 32'h00000080);
    run_req(MEM_OPT_LW, 32'h10, 32'h0);
    check("lw_after_sb", rsp_rdata, 32'h80ADBEEF);
    run_req(MEM_OPT_LBU, 32'h11, 32'h0);
    check("lbu_11", rsp_rdata, 32'h000000BE);
    run_req(MEM_OPT_LB, 32'h12, 32'h0);
    check("lb_12", rsp_rdata, 32'hFFFFFFAD);
    run_req(MEM_OPT_LW, 32'h10, 32'h0);

    $display("[TB] back-to-back LW then SW");
    @(posedge clk); #1;
    req_opt = MEM_OPT_LW; req_addr = 32'h10;
    b2b_busy = 0; gap = 0;
    @(negedge clk); if (busy) b2b_busy++;
    @(posedge clk); #1; req_opt = MEM_OPT_NONE;
    repeat (W + 1) begin
      @(negedge clk); if (busy) b2b_busy++; else gap++;
      @(posedge clk); #1;
    end
    req_opt = MEM_OPT_SW; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk); if (busy) b2b_busy++; else gap++;
      @(posedge clk); #1; req_opt = MEM_OPT_NONE;
    end
    @(negedge clk);
    check("b2b_busy_cycles", b2b_busy, 8);
    check("b2b_gap", gap, 0);
    check("b2b_idle_after", busy, 0);
    check("b2b_rdata_held", rsp_rdata, 32'h80ADBEEF);
    run_req(MEM_OPT_LW, 32'h20, 32'h0);
    check("b2b_store_landed", rsp_rdata, 32'hCAFEF00D);

    $display("[TB] reset during store");
    run_req(MEM_OPT_SW, 32'h30, 32'h11223344);
    @(posedge clk); #1;
    req_opt = MEM_OPT_SW; req_addr = 32'h30; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_opt = MEM_OPT_NONE; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_we_n", sram_we_n, 1);
    check("rstmid_ce_n", sram_ce_n, 1);
    check("rstmid_doe", sram_doe, 0);
    check("rstmid_rdata", rsp_rdata, 32'h0);
    run_req(MEM_OPT_LW, 32'h30, 32'h0);
    check("rstmid_old_contents", rsp_rdata, 32'h11223344);

    $display("[TB] misaligned word load");
    run_req(MEM_OPT_LW, 32'h12, 32'h0);
    if (ALIGN_EN) begin
      check("mis_err_pulses", r_err, 1);
      check("mis_ce_cycles", r_ce, 0);
      check("mis_busy_cycles", r_busy, 2);
      mis_expect = 32'h11223344;
    end else begin
      check("mis_err_pulses", r_err, 0);
      check("mis_busy_cycles", r_busy, 4);
      mis_expect = 32'h80ADBEEF;
    end
    check("mis_rdata", rsp_rdata, mis_expect);

    $display("[TB] reserved opcodes");
    idle_hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      req_opt   = 3'(6 + $urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      if (busy || !sram_ce_n) idle_hits++;
    end
    @(posedge clk); #1; req_opt = MEM_OPT_NONE;
    check("idle_no_activity", idle_hits, 0);
    check("idle_rdata_held", rsp_rdata, mis_expect);

    repeat (2) @(posedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
